time_set_sequencer: RTL and testbench
=====================================

// Module: time_set_sequencer
// PURPOSE
//  Keypad-driven time-set controller for the digital clock. Captures the running time into a shadow
//  register, walks an edit cursor across the six BCD digits, and rejects illegal digits per position.
//  Commits the new time to the time-counter block with a load_req/load_ack handshake.
//  Sits between the keypad decoder (key_value/key_flag) and the hour/minute/second counter chain.
//  All logic is synchronous to clk; there is no negedge key_flag clocking.
// PARAMETERS
//  KEY_SET       4'd1   key code: enter set mode / advance cursor / commit
//  KEY_CANCEL    4'd12  key code: abort edit, no load
//  WRONG_CYCLES  16     wrong_led stretch length in clk cycles (>=1)
//  ACK_TIMEOUT   255    max cycles in WAIT_ACK before abort (>=1)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  key_value   in   4   keypad code. Digits: 15=1 14=2 13=3 11=4 10=5 9=6 7=7 6=8 5=9 2=0
//  key_flag    in   1   synchronous level, high while a key is decoded
//  hour_g, hour_d, minute_g, minute_d, second_g, second_d   in 4 each   live time; _g=tens, _d=units
//  set_active  out  1   high in CAPTURE/EDIT/COMMIT/WAIT_ACK
//  cursor      out  3   edit position: 0=second_d 1=second_g 2=minute_d 3=minute_g 4=hour_d 5=hour_g
//  shadow_time out  24  {hour_g,hour_d,minute_g,minute_d,second_g,second_d} being edited
//  load_req    out  1   held high in WAIT_ACK; counter loads shadow_time when it sees it
//  load_ack    in   1   counter has loaded; sampled only in WAIT_ACK
//  wrong_led   out  1   stretched error indication
// BEHAVIOUR
//  Reset: state=IDLE. set_active=0, cursor=0, shadow_time=0, load_req=0, wrong_led=0.
//    Internal key_flag delay register=0.
//  Key event: one-cycle strobe when key_flag is 1 and was 0 on the previous cycle.
//    key_value is sampled in that same cycle. Holding a key produces one event.
//  IDLE: KEY_SET event -> CAPTURE. All other keys are ignored.
//  CAPTURE (1 cycle): shadow_time<=live digits; cursor<=0 -> EDIT.
//  EDIT:
//   - Digit event: write shadow[cursor] if legal; otherwise leave it unchanged and fire wrong.
//   - Legal digit limits per cursor position:
//       pos 1 and 3: <=5
//       pos 5: <=2; value 2 is legal only if shadow hour_d<=3
//       pos 4: <=3 if shadow hour_g==2, else <=9
//       pos 0 and 2: <=9
//   - KEY_SET event: cursor<5 -> cursor+1; cursor==5 -> COMMIT.
//   - KEY_CANCEL event -> IDLE. Shadow is discarded and no load is issued.
//   - Any other key code is ignored.
//  COMMIT (1 cycle): full check (hour<=23, min<=59, sec<=59).
//   - Fail: fire wrong, go to EDIT with cursor unchanged (5).
//   - Pass: WAIT_ACK.
//  WAIT_ACK:
//   - load_req=1 and shadow_time is held stable.
//   - load_ack=1 -> IDLE; load_req drops the next cycle.
//   - No ack after ACK_TIMEOUT cycles -> IDLE and fire wrong.
//   - KEY_CANCEL is ignored while waiting.
//  Wrong fire: wrong_led=1 for exactly WRONG_CYCLES cycles.
//    A new fire while wrong_led is lit restarts the count.
//  Simultaneous events: key event and ack/timeout in the same cycle -> the ack/timeout wins.
//    A key event is only acted on in IDLE/EDIT.
//  Reset asserted mid-operation: immediate return to the reset values. load_req drops asynchronously.
// CONFIGURATION
//  SET_BLINK_EN defined:
//   - Adds parameter BLINK_DIV (default 2**22) and output blink_mask[5:0].
//   - In EDIT, bit[cursor] toggles every BLINK_DIV cycles; all other bits are 1.
//   - Outside EDIT, blink_mask=6'b111111.
//   - A cursor move restarts the phase with the new bit at 1.
//  SET_BLINK_EN undefined: no blink_mask port, no divider logic. All other behaviour is identical.
// TESTING
//  1. Live 12:34:56; SET, keys 2,0 (pos0/1 ->0,2), SET x4, SET.
//     -> load_req with shadow 24'h123420; ack -> IDLE.
//  2. Cursor=1, key 9 (code 5) -> shadow unchanged; wrong_led high exactly WRONG_CYCLES cycles.
//  3. Shadow hour 19, cursor=5, key 2 (code 14) -> rejected (hour_d=9>3), wrong fired.
//     Then a subsequent key 1 is accepted.
//  4. KEY_CANCEL in EDIT after edits -> IDLE, load_req never asserted.
//     Next SET recaptures live time.
//  5. Commit with load_ack held low -> load_req high ACK_TIMEOUT cycles, then IDLE and wrong fired.
//     Separately, reset pulse during WAIT_ACK -> all outputs at reset values at once.
//  6. key_flag held 10 cycles on a digit -> single write.
//     SET_BLINK_EN: blink_mask[cursor] toggles at BLINK_DIV (use BLINK_DIV=4 in sim).

Source files
------------

// File: rtl/time_set_sequencer_if.sv
// Load bus between the time-set sequencer and the hour/minute/second counter chain.
// The sequencer (master) presents shadow_time and holds load_req until the counter
// (slave) answers with load_ack.
interface time_set_sequencer_if;
    logic        load_req;
    logic        load_ack;
    logic [23:0] shadow_time;

    modport master (
        output load_req,
        output shadow_time,
        input  load_ack
    );

    modport slave (
        input  load_req,
        input  shadow_time,
        output load_ack
    );
endinterface

// File: rtl/time_set_sequencer.sv
// Keypad-driven time-set controller for the digital clock.
// Captures the live time into a shadow register, lets the user edit it digit by digit
// with per-position legality checks, then commits it over a load_req/load_ack handshake.
// Optional feature macro: SET_BLINK_EN adds BLINK_DIV and the blink_mask output that
// flashes the digit under the edit cursor.
module time_set_sequencer #(
    parameter logic [3:0] KEY_SET      = 4'd1,
    parameter logic [3:0] KEY_CANCEL   = 4'd12,
    parameter int         WRONG_CYCLES = 16,
    parameter int         ACK_TIMEOUT  = 255
`ifdef SET_BLINK_EN
    ,
    parameter int         BLINK_DIV    = 2**22
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  key_value,
    input  logic                        key_flag,
    input  logic [3:0]                  hour_g,
    input  logic [3:0]                  hour_d,
    input  logic [3:0]                  minute_g,
    input  logic [3:0]                  minute_d,
    input  logic [3:0]                  second_g,
    input  logic [3:0]                  second_d,
    output logic                        set_active,
    output logic [2:0]                  cursor,
    output logic                        wrong_led,
`ifdef SET_BLINK_EN
    output logic [5:0]                  blink_mask,
`endif
    time_set_sequencer_if.master        load_bus
);

    localparam int WRONG_W = $clog2(WRONG_CYCLES + 1);
    localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EDIT,
        S_COMMIT,
        S_WAIT_ACK
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 key_flag_q;
    logic                 key_evt;
    logic                 is_set;
    logic                 is_cancel;
    logic                 digit_valid;
    logic [3:0]           digit_val;
    logic                 digit_legal;
    logic                 commit_ok;
    logic                 hour_ok;
    logic                 ack_expired;
    logic [2:0]           cursor_q;
    logic [23:0]          shadow_q;
    logic [WRONG_W-1:0]   wrong_cnt_q;
    logic [ACK_W-1:0]     ack_cnt_q;
    logic                 req_active;
    logic                 do_capture;
    logic                 do_write;
    logic                 cursor_inc;
    logic                 wrong_fire;

    // Keypad code to {valid, BCD value}; SET, CANCEL and unused codes are not digits.
    function automatic logic [4:0] decode_digit(input logic [3:0] code);
        case (code)
            4'd15:   return {1'b1, 4'd1};
            4'd14:   return {1'b1, 4'd2};
            4'd13:   return {1'b1, 4'd3};
            4'd11:   return {1'b1, 4'd4};
            4'd10:   return {1'b1, 4'd5};
            4'd9:    return {1'b1, 4'd6};
            4'd7:    return {1'b1, 4'd7};
            4'd6:    return {1'b1, 4'd8};
            4'd5:    return {1'b1, 4'd9};
            4'd2:    return {1'b1, 4'd0};
            default: return 5'd0;
        endcase
    endfunction

    assign key_evt                  = key_flag && !key_flag_q;
    assign is_set                   = key_evt && (key_value == KEY_SET);
    assign is_cancel                = key_evt && (key_value == KEY_CANCEL);
    assign {digit_valid, digit_val} = decode_digit(key_value);

    // A full time is legal when hours are 00..23 and minutes/seconds are 00..59.
    assign hour_ok   = ((shadow_q[23:20] <= 4'd1) && (shadow_q[19:16] <= 4'd9)) ||
                       ((shadow_q[23:20] == 4'd2) && (shadow_q[19:16] <= 4'd3));
    assign commit_ok = hour_ok &&
                       (shadow_q[15:12] <= 4'd5) && (shadow_q[11:8] <= 4'd9) &&
                       (shadow_q[7:4]   <= 4'd5) && (shadow_q[3:0]  <= 4'd9);

    assign ack_expired = (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));

    // Per-position digit limit, judged against the digits already in the shadow.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        digit_legal = 1'b1;
        case (cursor_q)
            3'd1, 3'd3: digit_legal = (digit_val <= 4'd5);
            3'd4:       digit_legal = (shadow_q[23:20] != 4'd2) || (digit_val <= 4'd3);
            3'd5:       digit_legal = (digit_val <= 4'd1) ||
                                      ((digit_val == 4'd2) && (shadow_q[19:16] <= 4'd3));
            default:    digit_legal = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic; keys only matter in IDLE/EDIT, ack/timeout only in WAIT_ACK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (is_set) state_d = S_CAPTURE;
            S_CAPTURE:  state_d = S_EDIT;
            S_EDIT: begin
                if (is_set && (cursor_q == 3'd5)) state_d = S_COMMIT;
                else if (is_cancel)               state_d = S_IDLE;
            end
            S_COMMIT:   state_d = commit_ok ? S_WAIT_ACK : S_EDIT;
            S_WAIT_ACK: if (load_bus.load_ack || ack_expired) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes decoded from the current state.
    always_comb begin
        set_active = 1'b1;
        req_active = 1'b0;
        do_capture = 1'b0;
        do_write   = 1'b0;
        cursor_inc = 1'b0;
        wrong_fire = 1'b0;
        case (state_q)
            S_IDLE:     set_active = 1'b0;
            S_CAPTURE:  do_capture = 1'b1;
            S_EDIT: begin
                if (key_evt && digit_valid) begin
                    do_write   = digit_legal;
                    wrong_fire = !digit_legal;
                end
                cursor_inc = is_set && (cursor_q != 3'd5);
            end
            S_COMMIT:   wrong_fire = !commit_ok;
            S_WAIT_ACK: begin
                req_active = 1'b1;
                wrong_fire = !load_bus.load_ack && ack_expired;
            end
            default:    set_active = 1'b0;
        endcase
    end

    // Key edge detector: remembers last cycle's key_flag level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) key_flag_q <= 1'b0;
        else        key_flag_q <= key_flag;
    end

    // Edit cursor: cleared on capture, advanced by SET while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          cursor_q <= 3'd0;
        else if (do_capture) cursor_q <= 3'd0;
        else if (cursor_inc) cursor_q <= cursor_q + 3'd1;
    end

    // Shadow time: loaded from the live counters, then patched one digit at a time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= 24'd0;
        end else if (do_capture) begin
            shadow_q <= {hour_g, hour_d, minute_g, minute_d, second_g, second_d};
        end else if (do_write) begin
            for (int i = 0; i < 6; i++) begin
                if (cursor_q == 3'(i)) shadow_q[i*4 +: 4] <= digit_val;
            end
        end
    end

    // Handshake timer: counts cycles spent waiting for load_ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      ack_cnt_q <= '0;
        else if (state_q != S_WAIT_ACK)  ack_cnt_q <= '0;
        else if (!ack_expired)           ack_cnt_q <= ack_cnt_q + ACK_W'(1);
    end

    // Error stretcher: each fire (re)loads the full lit duration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                wrong_cnt_q <= '0;
        else if (wrong_fire)       wrong_cnt_q <= WRONG_W'(WRONG_CYCLES);
        else if (wrong_cnt_q != 0) wrong_cnt_q <= wrong_cnt_q - WRONG_W'(1);
    end

    assign wrong_led            = (wrong_cnt_q != '0);
    assign cursor               = cursor_q;
    assign load_bus.load_req    = req_active;
    assign load_bus.shadow_time = shadow_q;

`ifdef SET_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    // Blink divider: parked lit outside EDIT and restarted lit on every cursor move.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if ((state_q != S_EDIT) || cursor_inc) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= !blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
        end
    end

    // Only the digit under the cursor blinks, and only while editing.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            blink_mask[i] = (state_q != S_EDIT) || (cursor_q != 3'(i)) || blink_phase_q;
        end
    end
`endif

endmodule

// File: tb/tb_time_set_sequencer.sv
// Self-checking bench for time_set_sequencer: a digit-array model of the time-set
// procedure is compared against the DUT every cycle, and directed scenarios pin
// hand-computed values (capture, edits, rejects, commit, timeout, reset).
module tb_time_set_sequencer;

    localparam int WRONG_CYCLES = 16;
    localparam int ACK_TIMEOUT  = 255;
`ifdef SET_BLINK_EN
    localparam int BLINK_DIV    = 4;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       key_flag = 1'b0;
    logic [3:0] hour_g = 4'd0, hour_d = 4'd0, minute_g = 4'd0;
    logic [3:0] minute_d = 4'd0, second_g = 4'd0, second_d = 4'd0;
    logic       set_active;
    logic [2:0] cursor;
    logic       wrong_led;
`ifdef SET_BLINK_EN
    logic [5:0] blink_mask;
`endif

    time_set_sequencer_if load_bus();

    time_set_sequencer #(
        .KEY_SET      (4'd1),
        .KEY_CANCEL   (4'd12),
        .WRONG_CYCLES (WRONG_CYCLES),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
`ifdef SET_BLINK_EN
        ,
        .BLINK_DIV    (BLINK_DIV)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_value  (key_value),
        .key_flag   (key_flag),
        .hour_g     (hour_g),
        .hour_d     (hour_d),
        .minute_g   (minute_g),
        .minute_d   (minute_d),
        .second_g   (second_g),
        .second_d   (second_d),
        .set_active (set_active),
        .cursor     (cursor),
        .wrong_led  (wrong_led),
`ifdef SET_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .load_bus   (load_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 capture, 2 edit, 3 commit, 4 waiting for ack.
    int dmap[16] = '{-1, -1, 0, -1, -1, 9, 8, 7, -1, 6, 5, 4, -1, 3, 2, 1};
    int m_mode, m_cur, m_wleft, m_wait, m_bn;
    int m_dig[6];
    bit m_kfq;

    function automatic logic [23:0] m_pack();
        logic [23:0] s;
        for (int i = 0; i < 6; i++) s[i*4 +: 4] = 4'(m_dig[i]);
        return s;
    endfunction

    function automatic bit m_legal(int pos, int d);
        case (pos)
            1, 3:    return d <= 5;
            4:       return (m_dig[5] == 2) ? (d <= 3) : 1'b1;
            5:       return (d <= 1) || (d == 2 && m_dig[4] <= 3);
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        int pm, pc, d;
        bit evt, fire;
        if (!reset) begin
            m_mode = 0; m_cur = 0; m_wleft = 0; m_wait = 0; m_bn = 0; m_kfq = 1'b0;
            for (int i = 0; i < 6; i++) m_dig[i] = 0;
        end else begin
            pm = m_mode; pc = m_cur; fire = 1'b0;
            evt = key_flag && !m_kfq;
            m_kfq = key_flag;
            case (m_mode)
                0: if (evt && key_value == 4'd1) m_mode = 1;
                1: begin
                    m_dig[5] = hour_g;   m_dig[4] = hour_d;
                    m_dig[3] = minute_g; m_dig[2] = minute_d;
                    m_dig[1] = second_g; m_dig[0] = second_d;
                    m_cur = 0; m_mode = 2;
                end
                2: if (evt) begin
                    d = dmap[key_value];
                    if (d >= 0) begin
                        if (m_legal(m_cur, d)) m_dig[m_cur] = d;
                        else fire = 1'b1;
                    end else if (key_value == 4'd1) begin
                        if (m_cur < 5) m_cur++;
                        else m_mode = 3;
                    end else if (key_value == 4'd12) begin
                        m_mode = 0;
                    end
                end
                3: begin
                    if ((m_dig[5] * 10 + m_dig[4] <= 23) && m_dig[4] <= 9 && m_dig[3] <= 5 &&
                        m_dig[2] <= 9 && m_dig[1] <= 5 && m_dig[0] <= 9) begin
                        m_mode = 4; m_wait = 0;
                    end else begin
                        m_mode = 2; fire = 1'b1;
                    end
                end
                4: begin
                    if (load_bus.load_ack) m_mode = 0;
                    else if (m_wait + 1 >= ACK_TIMEOUT) begin m_mode = 0; fire = 1'b1; end
                    else m_wait++;
                end
                default: m_mode = 0;
            endcase
            if (fire) m_wleft = WRONG_CYCLES;
            else if (m_wleft > 0) m_wleft--;
            if (m_mode == 2) begin
                if (pm != 2 || pc != m_cur) m_bn = 0;
                else m_bn++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run) begin
            check("set_active", set_active, m_mode != 0);
            check("cursor", cursor, m_cur);
            check("shadow_time", load_bus.shadow_time, m_pack());
            check("load_req", load_bus.load_req, m_mode == 4);
            check("wrong_led", wrong_led, m_wleft > 0);
`ifdef SET_BLINK_EN
            begin
                logic [5:0] em;
                for (int i = 0; i < 6; i++)
                    em[i] = !(m_mode == 2 && m_cur == i) || ((m_bn / BLINK_DIV) % 2 == 0);
                check("blink_mask", blink_mask, em);
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] code);
        key_value = code;
        key_flag  = 1'b1;
        tick();
        key_flag  = 1'b0;
        tick();
    endtask

    task automatic set_live(input logic [23:0] t);
        {hour_g, hour_d, minute_g, minute_d, second_g, second_d} = t;
    endtask

    task automatic cursor_to(input int n);
        for (int i = 0; i < n; i++) press(4'd1);
    endtask

    initial begin
        int n;
        load_bus.load_ack = 1'b0;
        repeat (3) tick();
        check("reset_set_active", set_active, 1'b0);
        check("reset_cursor", cursor, 3'd0);
        check("reset_shadow", load_bus.shadow_time, 24'h000000);
        check("reset_load_req", load_bus.load_req, 1'b0);
        check("reset_wrong_led", wrong_led, 1'b0);
        run = 1'b1;
        reset = 1'b1;
        tick();

        // 1: capture 12:34:56, seconds edited to 20, commit and acknowledge.
        set_live(24'h123456);
        press(4'd1);
        check("t1_capture", load_bus.shadow_time, 24'h123456);
        check("t1_cursor0", cursor, 3'd0);
        press(4'd2);
        press(4'd1);
        press(4'd14);
        cursor_to(4);
        check("t1_cursor5", cursor, 3'd5);
        check("t1_model_shadow", m_pack(), 24'h123420);
        press(4'd1);
        check("t1_load_req", load_bus.load_req, 1'b1);
        check("t1_shadow", load_bus.shadow_time, 24'h123420);
        press(4'd12);
        check("t1_cancel_ignored", load_bus.load_req, 1'b1);
        load_bus.load_ack = 1'b1;
        tick();
        load_bus.load_ack = 1'b0;
        check("t1_req_dropped", load_bus.load_req, 1'b0);
        check("t1_idle", set_active, 1'b0);
        check("t1_no_wrong", wrong_led, 1'b0);

        // 2: digit 9 at seconds-tens rejected; lamp lit exactly WRONG_CYCLES cycles.
        press(4'd1);
        press(4'd1);
        key_value = 4'd5;
        key_flag  = 1'b1;
        tick();
        key_flag  = 1'b0;
        n = 0;
        while (wrong_led && n < 100) begin n++; tick(); end
        check("t2_wrong_len", n, WRONG_CYCLES);
        check("t2_shadow_kept", load_bus.shadow_time, 24'h123456);
        press(4'd12);

        // 3: hour 19, tens digit 2 rejected, then 0 and 1 accepted.
        set_live(24'h190000);
        press(4'd1);
        cursor_to(5);
        press(4'd14);
        check("t3_reject", load_bus.shadow_time, 24'h190000);
        check("t3_wrong", wrong_led, 1'b1);
        press(4'd2);
        check("t3_accept0", load_bus.shadow_time, 24'h090000);
        press(4'd15);
        check("t3_accept1", load_bus.shadow_time, 24'h190000);
        press(4'd12);

        // Hour units limited to 3 once hour tens is 2; then 2 at tens legal.
        set_live(24'h200000);
        press(4'd1);
        cursor_to(4);
        press(4'd11);
        check("t3b_reject4", load_bus.shadow_time, 24'h200000);
        press(4'd13);
        check("t3b_accept3", load_bus.shadow_time, 24'h230000);
        press(4'd1);
        press(4'd1);
        check("t3b_load_req", load_bus.load_req, 1'b1);
        load_bus.load_ack = 1'b1;
        tick();
        load_bus.load_ack = 1'b0;

        // Commit of an illegal live time (29h) bounces back to EDIT at cursor 5.
        repeat (20) tick();
        set_live(24'h290000);
        press(4'd1);
        cursor_to(6);
        check("commit_fail_edit", set_active, 1'b1);
        check("commit_fail_cursor", cursor, 3'd5);
        check("commit_fail_req", load_bus.load_req, 1'b0);
        check("commit_fail_wrong", wrong_led, 1'b1);
        press(4'd12);

        // 4: cancel after edits, then a fresh SET recaptures the live time.
        set_live(24'h123456);
        press(4'd1);
        press(4'd7);
        check("t4_edit", load_bus.shadow_time, 24'h123457);
        press(4'd12);
        check("t4_idle", set_active, 1'b0);
        check("t4_no_req", load_bus.load_req, 1'b0);
        set_live(24'h081530);
        press(4'd1);
        check("t4_recapture", load_bus.shadow_time, 24'h081530);
        press(4'd12);

        // 5: no ack -> ACK_TIMEOUT cycles of load_req, then IDLE with wrong lit.
        press(4'd1);
        cursor_to(6);
        n = 0;
        while (load_bus.load_req && n < 1000) begin n++; tick(); end
        check("t5_req_len", n, ACK_TIMEOUT);
        check("t5_idle", set_active, 1'b0);
        check("t5_wrong", wrong_led, 1'b1);
        // Reset pulse while waiting: outputs return to reset values immediately.
        press(4'd1);
        cursor_to(6);
        check("t5_waiting", load_bus.load_req, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_req", load_bus.load_req, 1'b0);
        check("t5_rst_active", set_active, 1'b0);
        check("t5_rst_cursor", cursor, 3'd0);
        check("t5_rst_shadow", load_bus.shadow_time, 24'h000000);
        check("t5_rst_wrong", wrong_led, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // 6: held keys produce a single event each.
        set_live(24'h123456);
        press(4'd1);
`ifdef SET_BLINK_EN
        check("t6_blink_lit", blink_mask, 6'h3F);
        repeat (BLINK_DIV) tick();
        check("t6_blink_dark", blink_mask, 6'h3E);
`endif
        key_value = 4'd1;
        key_flag  = 1'b1;
        repeat (10) tick();
        key_flag  = 1'b0;
        tick();
        check("t6_single_move", cursor, 3'd1);
        key_value = 4'd5;
        key_flag  = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrong_led) n++;
        end
        key_flag = 1'b0;
        while (wrong_led && n < 100) begin tick(); if (wrong_led) n++; end
        check("t6_single_wrong", n, WRONG_CYCLES);
        check("t6_shadow_kept", load_bus.shadow_time, 24'h123456);
        press(4'd12);
        repeat (3) tick();

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
